serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing z = x - y - bin, one bit per clock, LSB first.
- Inverse-direction companion to the team's combinational ripple adder; serves as the area-light subtract path in the lab datapath.
- Uses a start/busy/done handshake.
- Provides an unsigned borrow-out and a two's-complement overflow flag.

---
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: z = x - y - bin, one bit per clock, LSB first.
// start/busy/done handshake; unsigned borrow-out and signed overflow flag.
module serial_subtractor #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic [WIDTH-1:0] z,
   output logic             borrow,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_sh_q, x_sh_d;
   logic [WIDTH-1:0] y_sh_q, y_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             xm_q, xm_d;
   logic             ym_q, ym_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbit_c;
   logic             bnext_c;

   // One full-subtractor cell on the current LSBs and running borrow
   always_comb begin
      dbit_c  = x_sh_q[0] ^ y_sh_q[0] ^ br_q;
      bnext_c = (~x_sh_q[0] & y_sh_q[0]) | (~(x_sh_q[0] ^ y_sh_q[0]) & br_q);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      x_sh_d   = x_sh_q;
      y_sh_d   = y_sh_q;
      res_d    = res_q;
      z_d      = z_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      xm_d     = xm_q;
      ym_d     = ym_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               x_sh_d  = x;
               y_sh_d  = y;
               xm_d    = x[WIDTH-1];
               ym_d    = y[WIDTH-1];
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            x_sh_d = x_sh_q >> 1;
            y_sh_d = y_sh_q >> 1;
            res_d  = {dbit_c, res_q[WIDTH-1:1]};
            br_d   = bnext_c;
            cnt_d  = cnt_q + CW'(1);
            // Last bit: publish the result, flags and the done pulse together
            if (cnt_q == CW'(WIDTH - 1)) begin
               z_d      = {dbit_c, res_q[WIDTH-1:1]};
               borrow_d = bnext_c;
               ovf_d    = (xm_q != ym_q) & (dbit_c != xm_q);
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_sh_q   <= '0;
         y_sh_q   <= '0;
         res_q    <= '0;
         z_q      <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         xm_q     <= 1'b0;
         ym_q     <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_sh_q   <= x_sh_d;
         y_sh_q   <= y_sh_d;
         res_q    <= res_d;
         z_q      <= z_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         xm_q     <= xm_d;
         ym_q     <= ym_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign z      = z_q;
   assign borrow = borrow_q;
   assign ovf    = ovf_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

   localparam int unsigned W = 5;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         bin;
   logic [W-1:0] z;
   logic         borrow;
   logic         ovf;
   logic         busy;
   logic         done;

   typedef struct {
      logic [W-1:0] z;
      logic         b;
      logic         o;
   } exp_t;

   exp_t sb_q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   done_seen = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .x      (x),
      .y      (y),
      .bin    (bin),
      .z      (z),
      .borrow (borrow),
      .ovf    (ovf),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_seen++;
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (z=%0d)", z);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("z", int'(z), int'(e.z));
            chk("borrow", int'(borrow), int'(e.b));
            chk("ovf", int'(ovf), int'(e.o));
         end
      end
   end

   // Issue one operation and wait (bounded) for its done pulse.
   // Returns number of negedges until done and busy-high negedges seen.
   task automatic op(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic bi,
                     input logic [W-1:0] ez, input logic eb, input logic eo,
                     output int n, output int busy_cnt);
      exp_t e;
      x = xi; y = yi; bin = bi; start = 1'b1;
      e.z = ez; e.b = eb; e.o = eo;
      sb_q.push_back(e);
      n = 0;
      busy_cnt = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n++;
         if (busy) busy_cnt++;
      end while (!done && n < 20);
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL timeout: got no done after %0d cycles expected done", n);
      end
   endtask

   initial begin
      int n, bc, ds;
      rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
      #12;
      chk("rst_z", int'(z), 0);
      chk("rst_borrow", int'(borrow), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Basic op with latency / busy-width check
      op(5'd13, 5'd6, 1'b0, 5'd7, 1'b0, 1'b0, n, bc);
      chk("latency", n, W + 1);
      chk("busy_width", bc, W);
      chk("busy_in_done", int'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);

      // Directed vectors
      op(5'd6,  5'd13, 1'b0, 5'd25, 1'b1, 1'b0, n, bc);
      @(negedge clk);
      op(5'd0,  5'd0,  1'b1, 5'd31, 1'b1, 1'b0, n, bc);
      @(negedge clk);
      op(5'd31, 5'd31, 1'b0, 5'd0,  1'b0, 1'b0, n, bc);
      @(negedge clk);
      op(5'd15, 5'd16, 1'b0, 5'd31, 1'b1, 1'b1, n, bc);
      @(negedge clk);
      op(5'd16, 5'd1,  1'b0, 5'd15, 1'b0, 1'b1, n, bc);
      @(negedge clk);
      op(5'd10, 5'd10, 1'b1, 5'd31, 1'b1, 1'b0, n, bc);
      @(negedge clk);

      // start while busy is ignored; inputs may change after capture
      ds = done_seen;
      begin
         exp_t e;
         x = 5'd13; y = 5'd6; bin = 1'b0; start = 1'b1;
         e.z = 5'd7; e.b = 1'b0; e.o = 1'b0;
         sb_q.push_back(e);
         @(negedge clk); start = 1'b0; x = 5'd22; y = 5'd3;
         @(negedge clk); start = 1'b1; x = 5'd1; y = 5'd1; bin = 1'b1;
         @(negedge clk); start = 1'b0; x = 5'd9; y = 5'd30;
         repeat (12) @(negedge clk);
      end
      chk("ignored_start_dones", done_seen - ds, 1);
      chk("z_held", int'(z), 7);

      // Back-to-back: start held in the done cycle
      op(5'd13, 5'd6, 1'b0, 5'd7, 1'b0, 1'b0, n, bc);
      op(5'd20, 5'd3, 1'b0, 5'd17, 1'b0, 1'b0, n, bc);
      chk("b2b_latency", n, W + 1);
      chk("b2b_busy", bc, W);
      @(negedge clk);

      // Asynchronous reset mid-run discards the operation
      ds = done_seen;
      x = 5'd13; y = 5'd6; bin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_z", int'(z), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_borrow", int'(borrow), 0);
      chk("arst_ovf", int'(ovf), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_done_after_rst", done_seen - ds, 0);
      op(5'd9, 5'd4, 1'b0, 5'd5, 1'b0, 1'b0, n, bc);
      @(negedge clk);

      chk("pending", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
